// File: rtl/stream_arb_pkg.sv
// Shared types and the wrap-around one-hot search used by the stream mux arbiter.
package stream_arb_pkg;

    typedef enum logic [1:0] {
        ARB_STATIC = 2'b00,
        ARB_FIXED  = 2'b01,
        ARB_RR     = 2'b10,
        ARB_RSVD   = 2'b11
    } arb_mode_e;

    // Widest channel count the search helper handles.
    localparam int MAX_CH = 32;
    localparam int MAX_W  = $clog2(MAX_CH);

    // First set bit of req, scanning start, start+1, ... modulo n.
    // Returns a one-hot vector (all zero when nothing in range is set).
    function automatic logic [MAX_CH-1:0] first_onehot(
        input logic [MAX_CH-1:0] req,
        input int unsigned       start,
        input int unsigned       n
    );
        logic [MAX_CH-1:0] g;
        logic              found;
        int unsigned       idx;
        g     = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_CH; k++) begin
            if (k < n && !found) begin
                idx = start + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (req[idx[MAX_W-1:0]]) begin
                    g[idx[MAX_W-1:0]] = 1'b1;
                    found             = 1'b1;
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/stream_arb_mux_rr_arbiter.sv
// Grant generation for the stream mux: static select, fixed priority and
// round robin, plus the round-robin start pointer.
module rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic [1:0]        mode,
    input  logic [CH_W-1:0]   sel,
    input  logic              advance,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   grant_idx
);

    localparam logic [CH_W:0] CH_LIMIT = (CH_W+1)'(NUM_CH);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    logic [CH_W-1:0]   rr_ptr_reg;
    logic [CH_W-1:0]   rr_ptr_next;
    logic [MAX_CH-1:0] req_ext;
    logic [MAX_CH-1:0] fixed_oh;
    logic [MAX_CH-1:0] rr_oh;

    assign req_ext  = MAX_CH'(req);
    assign fixed_oh = first_onehot(req_ext, 32'd0, NUM_CH);
    assign rr_oh    = first_onehot(req_ext, 32'(rr_ptr_reg), NUM_CH);

    // The search works on a fixed-width vector; bits above NUM_CH are always zero.
    generate
        if (NUM_CH < MAX_CH) begin : g_hi_sink
            logic unused_hi;
            assign unused_hi = ^{fixed_oh[MAX_CH-1:NUM_CH], rr_oh[MAX_CH-1:NUM_CH]};
        end
    endgenerate

    // Select the grant vector for the active mode; reserved mode aliases fixed priority.
    always_comb begin
        grant = '0;
        case (arb_mode_e'(mode))
            ARB_STATIC: begin
                if ({1'b0, sel} < CH_LIMIT) begin
                    grant[sel] = req[sel];
                end
            end
            ARB_RR:  grant = rr_oh[NUM_CH-1:0];
            default: grant = fixed_oh[NUM_CH-1:0];
        endcase
    end

    // Encode the one-hot grant into a channel index.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                grant_idx = CH_W'(i);
            end
        end
    end

    // Next round-robin start is one past the winner, wrapping at the last channel.
    always_comb begin
        rr_ptr_next = (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;
    end

    // Pointer moves only on an accepted word in round-robin mode; other modes leave it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg <= '0;
        end else if (advance && (mode == ARB_RR)) begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end

endmodule

// File: rtl/stream_arb_mux.sv
// N:1 valid/ready stream multiplexer with selectable arbitration and a single
// output register holding the winning word and its channel index.
module stream_arb_mux
    import stream_arb_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int WIDTH  = 2,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              mode,
    input  logic [CH_W-1:0]         sel,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]       in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]         out_ch,
    input  logic                    out_ready
);

    logic [NUM_CH-1:0] grant;
    logic [CH_W-1:0]   grant_idx;
    logic              load_en;
    logic              transfer;
    logic [WIDTH-1:0]  ch_data [NUM_CH];
    logic [WIDTH-1:0]  win_data;

    logic              out_valid_reg;
    logic [WIDTH-1:0]  out_data_reg;
    logic [CH_W-1:0]   out_ch_reg;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (in_valid),
        .mode      (mode),
        .sel       (sel),
        .advance   (transfer),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // The register can take a word when empty or when the consumer drains it this cycle.
    assign load_en  = !out_valid_reg || out_ready;
    // Reset keeps every producer stalled even though the register reads as empty.
    assign in_ready = (rst_n && load_en) ? grant : '0;
    assign transfer = |in_ready;
    assign win_data = ch_data[grant_idx];

    // Output register: capture the winner, go empty when nothing is granted, hold on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_ch_reg    <= '0;
        end else if (load_en) begin
            if (transfer) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= win_data;
                out_ch_reg    <= grant_idx;
            end else begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_ch    = out_ch_reg;

endmodule
